// File: rtl/fpadd_arbiter_if.sv
// Bundle of the two issue ports, the two response ports and the shared
// FP adder port, plus the busy flag.
interface fpadd_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [63:0] rsp0_data;
    logic        rsp0_err;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [63:0] rsp1_data;
    logic        rsp1_err;
    logic [1:0]  fpa_enabler;
    logic [63:0] fpa_a;
    logic [63:0] fpa_b;
    logic        fpa_start;
    logic [63:0] fpa_sum;
    logic        fpa_ready;
    logic        busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, fpa_sum, fpa_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_err,
        output rsp1_valid, rsp1_data, rsp1_err,
        output fpa_enabler, fpa_a, fpa_b, fpa_start, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, fpa_sum, fpa_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_err,
        input  rsp1_valid, rsp1_data, rsp1_err,
        input  fpa_enabler, fpa_a, fpa_b, fpa_start, busy
    );
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin controller sharing one multi-cycle FP64 adder between two
// requesters, with completion timeout and per-requester responses.
module fpadd_arbiter #(
    parameter int          TIMEOUT = 16,
    parameter logic [63:0] NAN_VAL = 64'h7FF8000000000000
) (
    input logic            clk,
    input logic            rst_n,
    fpadd_arbiter_if.slave bus
);
    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_gnt;
    logic          r_start;
    logic          r_rsp_valid;
    logic          r_err;
    logic [63:0]   r_a;
    logic [63:0]   r_b;
    logic [63:0]   r_data;
    logic [CW-1:0] r_cnt;

    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc;
    logic        w_rsp_rdy;
    logic [1:0]  w_op;
    logic [63:0] w_a;
    logic [63:0] w_b;

    // r_last names the previous winner, so the other side wins a tie
    assign w_idle = rst_n && (r_state == IDLE);
    assign w_gnt0 = w_idle && bus.req0_valid
                    && (!bus.req1_valid || r_last);
    assign w_gnt1 = w_idle && bus.req1_valid
                    && (!bus.req0_valid || !r_last);
    assign w_acc  = w_gnt0 || w_gnt1;

    assign w_op      = w_gnt1 ? bus.req1_op : bus.req0_op;
    assign w_a       = w_gnt1 ? bus.req1_a  : bus.req0_a;
    assign w_b       = w_gnt1 ? bus.req1_b  : bus.req0_b;
    assign w_rsp_rdy = r_gnt ? bus.rsp1_ready : bus.rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
        end else begin
            r_start <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_gnt  <= w_gnt1;
                        r_last <= w_gnt1;
                        if (w_op[1]) begin
                            r_data      <= '0;
                            r_err       <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            // subtraction is an add of the negated operand
                            r_a     <= w_a;
                            r_b     <= {w_b[63] ^ w_op[0], w_b[62:0]};
                            r_start <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.fpa_ready) begin
                        r_data      <= bus.fpa_sum;
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_cnt == LAST) begin
                        r_data      <= NAN_VAL;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (w_rsp_rdy) begin
                        r_rsp_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req0_ready  = w_gnt0;
    assign bus.req1_ready  = w_gnt1;
    assign bus.rsp0_valid  = r_rsp_valid && !r_gnt;
    assign bus.rsp1_valid  = r_rsp_valid && r_gnt;
    assign bus.rsp0_data   = r_data;
    assign bus.rsp1_data   = r_data;
    assign bus.rsp0_err    = r_err && !r_gnt;
    assign bus.rsp1_err    = r_err && r_gnt;
    assign bus.fpa_enabler = 2'b00;
    assign bus.fpa_a       = r_a;
    assign bus.fpa_b       = r_b;
    assign bus.fpa_start   = r_start;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_fpadd_arbiter.sv
// Randomised bench for fpadd_arbiter: behavioural adder stub plus a
// real-arithmetic reference model for results, grants and latency.
module tb_fpadd_arbiter;
    localparam int TO = 4;
    localparam logic [63:0] D1 = 64'h3FF0000000000000;
    localparam logic [63:0] D2 = 64'h4000000000000000;
    localparam logic [63:0] NAN = 64'h7FF8000000000000;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   model_last;
    int   adder_k;
    bit   inject;
    int   starts;

    fpadd_arbiter_if bus ();

    fpadd_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // adder stub: ready pulses in WAIT cycle adder_k (0 = never)
    initial begin : adder_stub
        int cd;
        logic [63:0] hold;
        cd = 0;
        hold = '0;
        bus.fpa_ready = 1'b0;
        bus.fpa_sum = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.fpa_ready = inject;
            if (!rst_n) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) bus.fpa_ready = 1'b1;
            end
            if (bus.fpa_start) begin
                starts++;
                hold = $realtobits($bitstoreal(bus.fpa_a)
                                   + $bitstoreal(bus.fpa_b));
                if (adder_k > 0) cd = adder_k;
            end
            bus.fpa_sum = hold;
        end
    end

    function automatic logic [63:0] ref_sum(input logic [1:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        real ra;
        real rb;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        if (op[1]) return 64'h0;
        if (op[0]) return $realtobits(ra - rb);
        return $realtobits(ra + rb);
    endfunction

    function automatic logic [63:0] rnd_dbl();
        return $realtobits(real'($urandom_range(0, 2000)) - 1000.0);
    endfunction

    task automatic drive_req(input int who, input logic v,
                             input logic [1:0] op,
                             input logic [63:0] a, input logic [63:0] b);
        if (who == 0) begin
            bus.req0_valid = v;
            bus.req0_op = op;
            bus.req0_a = a;
            bus.req0_b = b;
        end else begin
            bus.req1_valid = v;
            bus.req1_op = op;
            bus.req1_a = a;
            bus.req1_b = b;
        end
    endtask

    // returns one tick after the accept edge
    task automatic issue(input int who, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         output bit ok);
        ok = 1'b0;
        drive_req(who, 1'b1, op, a, b);
        for (int i = 0; i < 50 && !ok; i++) begin
            #2;
            ok = (who == 0) ? bus.req0_ready : bus.req1_ready;
            @(posedge clk);
            #1;
        end
        drive_req(who, 1'b0, op, a, b);
    endtask

    task automatic wait_rsp(output int lat, output int who);
        lat = 1;
        who = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp0_valid) begin
                who = 0;
                break;
            end
            if (bus.rsp1_valid) begin
                who = 1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_req(0, 1'b1, 2'b00, D1, D2);
        drive_req(1, 1'b1, 2'b00, D1, D2);
        #3;
        n_cmp++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_ready got %b exp 00",
                     {bus.req1_ready, bus.req0_ready});
        end
        n_cmp++;
        if ({bus.busy, bus.fpa_start, bus.rsp0_valid, bus.rsp1_valid,
             bus.rsp0_err, bus.rsp1_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_flags got %b exp 000000",
                     {bus.busy, bus.fpa_start, bus.rsp0_valid,
                      bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err});
        end
        n_cmp++;
        if ((bus.fpa_a | bus.fpa_b | bus.rsp0_data) !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_data got %h/%h/%h exp 0",
                     bus.fpa_a, bus.fpa_b, bus.rsp0_data);
        end
        n_cmp++;
        if (bus.fpa_enabler !== 2'b00) begin
            n_fail++;
            $display("FAIL enabler got %b exp 00", bus.fpa_enabler);
        end
        drive_req(0, 1'b0, 2'b00, 0, 0);
        drive_req(1, 1'b0, 2'b00, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_last = 1;
    endtask

    task automatic test_single_add;
        bit ok;
        int lat;
        int who;
        adder_k = 2;
        issue(0, 2'b00, D1, D2, ok);
        model_last = 0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL add_accept got 0 exp 1");
        end
        wait_rsp(lat, who);
        n_cmp++;
        if (who !== 0 || bus.rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_route got %0d exp 0", who);
        end
        n_cmp++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL add_lat got %0d exp 4", lat);
        end
        n_cmp++;
        if (bus.rsp0_data !== 64'h4008000000000000 || bus.rsp0_err) begin
            n_fail++;
            $display("FAIL add_data got %h/%b exp 4008000000000000/0",
                     bus.rsp0_data, bus.rsp0_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sub;
        bit ok;
        int lat;
        int who;
        adder_k = 1;
        issue(1, 2'b01, D2, D1, ok);
        model_last = 1;
        n_cmp++;
        if (!ok || bus.fpa_start !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_start got %b/%b exp 1/1", ok, bus.fpa_start);
        end
        n_cmp++;
        if (bus.fpa_b !== 64'hBFF0000000000000 || bus.fpa_a !== D2) begin
            n_fail++;
            $display("FAIL sub_opnd got %h exp bff0000000000000",
                     bus.fpa_b);
        end
        wait_rsp(lat, who);
        n_cmp++;
        if (who !== 1 || lat !== 3) begin
            n_fail++;
            $display("FAIL sub_route got %0d/%0d exp 1/3", who, lat);
        end
        n_cmp++;
        if (bus.rsp1_data !== D1 || bus.rsp1_err) begin
            n_fail++;
            $display("FAIL sub_data got %h/%b exp %h/0",
                     bus.rsp1_data, bus.rsp1_err, D1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention;
        logic [1:0]  op [2];
        logic [63:0] a [2];
        logic [63:0] b [2];
        logic [63:0] exp_d;
        int pend;
        int acc;
        int g;
        int just;
        pend = -1;
        acc = 0;
        just = -1;
        exp_d = '0;
        for (int r = 0; r < 2; r++) begin
            op[r] = 2'($urandom_range(0, 1));
            a[r] = rnd_dbl();
            b[r] = rnd_dbl();
            drive_req(r, 1'b1, op[r], a[r], b[r]);
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (just >= 0) begin
                op[just] = 2'($urandom_range(0, 1));
                a[just] = rnd_dbl();
                b[just] = rnd_dbl();
                drive_req(just, acc < 4, op[just], a[just], b[just]);
                just = -1;
            end
            if (acc >= 4) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                n_cmp++;
                if ({bus.rsp1_valid, bus.rsp0_valid}
                    !== ((pend == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL cont_route got %b exp req %0d",
                             {bus.rsp1_valid, bus.rsp0_valid}, pend);
                end
                n_cmp++;
                if (((pend == 1) ? bus.rsp1_data : bus.rsp0_data)
                    !== exp_d) begin
                    n_fail++;
                    $display("FAIL cont_data got %h exp %h",
                             (pend == 1) ? bus.rsp1_data : bus.rsp0_data,
                             exp_d);
                end
                pend = -1;
            end
            if (acc >= 4 && pend < 0) break;
            #2;
            if (acc < 4 && (bus.req0_ready || bus.req1_ready)) begin
                g = bus.req1_ready ? 1 : 0;
                n_cmp++;
                if ({bus.req1_ready, bus.req0_ready}
                    !== ((model_last == 1) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL cont_grant got %b after last %0d",
                             {bus.req1_ready, bus.req0_ready}, model_last);
                end
                model_last = g;
                exp_d = ref_sum(op[g], a[g], b[g]);
                pend = g;
                acc++;
                just = g;
                adder_k = $urandom_range(1, 3);
            end
            @(posedge clk);
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n_cmp++;
        if (acc != 4 || pend >= 0) begin
            n_fail++;
            $display("FAIL cont_done got %0d ops exp 4", acc);
        end
    endtask

    task automatic test_random;
        bit ok;
        int lat;
        int who;
        int req;
        logic [1:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] got;
        logic gerr;
        for (int n = 0; n < 10; n++) begin
            req = $urandom_range(0, 1);
            op = 2'($urandom_range(0, 3));
            a = rnd_dbl();
            b = rnd_dbl();
            adder_k = $urandom_range(1, 3);
            issue(req, op, a, b, ok);
            model_last = req;
            wait_rsp(lat, who);
            got = (who == 1) ? bus.rsp1_data : bus.rsp0_data;
            gerr = (who == 1) ? bus.rsp1_err : bus.rsp0_err;
            n_cmp++;
            if (!ok || who !== req
                || lat !== (op[1] ? 1 : adder_k + 2)) begin
                n_fail++;
                $display("FAIL rnd_route got %b/%0d/%0d exp req %0d op %b",
                         ok, who, lat, req, op);
            end
            n_cmp++;
            if (got !== ref_sum(op, a, b) || gerr !== op[1]) begin
                n_fail++;
                $display("FAIL rnd_data got %h/%b exp %h/%b",
                         got, gerr, ref_sum(op, a, b), op[1]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int lat;
        int who;
        int late;
        adder_k = 0;
        issue(0, 2'b00, rnd_dbl(), rnd_dbl(), ok);
        model_last = 0;
        wait_rsp(lat, who);
        n_cmp++;
        if (!ok || who !== 0 || lat !== 2 + TO) begin
            n_fail++;
            $display("FAIL to_lat got %0d/%0d exp 0/%0d", who, lat, 2 + TO);
        end
        n_cmp++;
        if (bus.rsp0_data !== NAN || bus.rsp0_err !== 1'b1) begin
            n_fail++;
            $display("FAIL to_data got %h/%b exp %h/1",
                     bus.rsp0_data, bus.rsp0_err, NAN);
        end
        @(posedge clk);
        #1;
        inject = 1'b1;
        late = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) inject = 1'b0;
            if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) late++;
        end
        n_cmp++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL to_late got %0d active cycles exp 0", late);
        end
    endtask

    task automatic test_reserved;
        bit ok;
        int lat;
        int who;
        int s0;
        adder_k = 1;
        s0 = starts;
        issue(1, 2'b10, D1, D2, ok);
        model_last = 1;
        wait_rsp(lat, who);
        n_cmp++;
        if (!ok || who !== 1 || lat !== 1) begin
            n_fail++;
            $display("FAIL rsv_lat got %0d/%0d exp 1/1", who, lat);
        end
        n_cmp++;
        if (bus.rsp1_data !== 64'h0 || bus.rsp1_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_data got %h/%b exp 0/1",
                     bus.rsp1_data, bus.rsp1_err);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (starts != s0) begin
            n_fail++;
            $display("FAIL rsv_start got %0d pulses exp 0", starts - s0);
        end
    endtask

    task automatic test_backpressure_reset;
        bit ok;
        int lat;
        int who;
        int bad_v;
        int bad_d;
        int bad_r;
        int quiet;
        logic [63:0] a;
        logic [63:0] b;
        a = rnd_dbl();
        b = rnd_dbl();
        bus.rsp0_ready = 1'b0;
        adder_k = 1;
        issue(0, 2'b00, a, b, ok);
        model_last = 0;
        wait_rsp(lat, who);
        n_cmp++;
        if (!ok || who !== 0 || lat !== 3) begin
            n_fail++;
            $display("FAIL bp_lat got %0d/%0d exp 0/3", who, lat);
        end
        drive_req(1, 1'b1, 2'b00, rnd_dbl(), rnd_dbl());
        bad_v = 0;
        bad_d = 0;
        bad_r = 0;
        repeat (5) begin
            #2;
            if (bus.rsp0_valid !== 1'b1) bad_v++;
            if (bus.rsp0_data !== ref_sum(2'b00, a, b)) bad_d++;
            if (bus.req1_ready !== 1'b0) bad_r++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (bad_v != 0 || bad_d != 0) begin
            n_fail++;
            $display("FAIL bp_hold got %0d/%0d unstable cycles exp 0",
                     bad_v, bad_d);
        end
        n_cmp++;
        if (bad_r != 0) begin
            n_fail++;
            $display("FAIL bp_block got %0d ready cycles exp 0", bad_r);
        end
        adder_k = 0;
        bus.rsp0_ready = 1'b1;
        @(posedge clk);
        #3;
        n_cmp++;
        if (bus.rsp0_valid !== 1'b0 || bus.req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got %b/%b exp 0/1",
                     bus.rsp0_valid, bus.req1_ready);
        end
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        model_last = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.fpa_start, bus.rsp0_valid, bus.rsp1_valid,
             bus.rsp0_err, bus.rsp1_err, bus.req0_ready, bus.req1_ready}
            !== 8'b0) begin
            n_fail++;
            $display("FAIL mid_rst_flags got %b exp 00000000",
                     {bus.busy, bus.fpa_start, bus.rsp0_valid,
                      bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err,
                      bus.req0_ready, bus.req1_ready});
        end
        n_cmp++;
        if ((bus.fpa_a | bus.fpa_b | bus.rsp1_data) !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_rst_data got %h/%h exp 0",
                     bus.fpa_a, bus.fpa_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_last = 1;
        #1;
        n_cmp++;
        if ({bus.req1_ready, bus.req0_ready}
            !== ((model_last == 1) ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL post_rst_grant got %b exp 01",
                     {bus.req1_ready, bus.req0_ready});
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        quiet = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) quiet++;
        end
        n_cmp++;
        if (quiet != 0) begin
            n_fail++;
            $display("FAIL abort_silent got %0d active cycles exp 0", quiet);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_last = 1;
        adder_k = 0;
        inject = 1'b0;
        starts = 0;
        rst_n = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive_req(0, 1'b0, 2'b00, 0, 0);
        drive_req(1, 1'b0, 2'b00, 0, 0);
        test_reset();
        test_single_add();
        test_sub();
        test_contention();
        test_random();
        test_timeout();
        test_reserved();
        test_backpressure_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
